systolic_skew_feeder: RTL and testbench

- Upstream feeder for one edge of the systolic MAC array.
- Accepts one N-lane fp16 activation vector per handshake and drives the array's row inputs diagonally skewed: lane i is delayed i+1 cycles.
- Generates the per-lane start pulses the MAC units need to advance their pipelines.
- After the last vector of a tile, drains the array and pulses done.

---
 rtl/systolic_skew_feeder_pkg.sv | 15 +
 rtl/systolic_skew_feeder_skew_delay_lane.sv | 47 ++++
 rtl/systolic_skew_feeder.sv | 145 ++++++++++++++
 tb/tb_systolic_skew_feeder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and defaults for the systolic array feeder (package systolic_pkg).
package systolic_pkg;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } feeder_state_e;

    localparam int unsigned DEFAULT_N        = 4;
    localparam int unsigned MAC_PIPE_LATENCY = 3;

endpackage : systolic_pkg

// File: rtl/systolic_skew_feeder_skew_delay_lane.sv
// One skew lane: enable-gated shift register of {value, start}, DEPTH stages,
// synchronous clear that wins over the enable.
module skew_delay_lane #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] in_val,
    input  logic              in_start,
    output logic [DATA_W-1:0] out_val,
    output logic              out_start
);

    logic [DEPTH-1:0][DATA_W-1:0] val_q, val_d;
    logic [DEPTH-1:0]             start_q, start_d;

    // Next chain contents: shift one stage when enabled, otherwise hold.
    always_comb begin
        val_d   = val_q;
        start_d = start_q;
        if (en) begin
            val_d[0]   = in_val;
            start_d[0] = in_start;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                val_d[i]   = val_q[i-1];
                start_d[i] = start_q[i-1];
            end
        end
    end

    // Chain registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            val_q   <= '0;
            start_q <= '0;
        end else begin
            val_q   <= val_d;
            start_q <= start_d;
        end
    end

    assign out_val   = val_q[DEPTH-1];
    assign out_start = start_q[DEPTH-1];

endmodule : skew_delay_lane

// File: rtl/systolic_skew_feeder.sv
// Skewed row feeder for one edge of the systolic MAC array. Lane i is delayed
// i+1 cycles; after the last vector of a tile the array is drained and done pulses.
// Optional macro SKEW_FEEDER_STALL_CNT_EN adds the stall_cycles output.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned N           = DEFAULT_N,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MAC_LATENCY = MAC_PIPE_LATENCY
) (
    input  logic                clk,
    input  logic                RST,
    input  logic [N*DATA_W-1:0] in_vec,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                hold,
    output logic [N*DATA_W-1:0] out_vec,
    output logic [N-1:0]        out_start,
    output logic                busy,
    output logic                done,
    output logic [15:0]         vec_count
`ifdef SKEW_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    localparam int unsigned        DRAIN_CYCLES = N + MAC_LATENCY;
    localparam int unsigned        CNT_W        = $clog2(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0]   DRAIN_LOAD   = CNT_W'(DRAIN_CYCLES - 1);

    feeder_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       vec_count_q, vec_count_d;
    logic              done_c;
    logic              acc;
    logic [N*DATA_W-1:0] lane_in;
    logic [N-1:0]      lane_start;

    assign in_ready = ~RST & ~hold & (state_q != DRAIN);
    assign acc      = in_valid & in_ready;
    // Bubbles enter the chains as value 0 so the array only sees real data.
    assign lane_in  = acc ? in_vec : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_delay_lane #(
            .DEPTH  (i + 1),
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .clr       (RST),
            .en        (~hold),
            .in_val    (lane_in[DATA_W*i +: DATA_W]),
            .in_start  (acc),
            .out_val   (out_vec[DATA_W*i +: DATA_W]),
            .out_start (lane_start[i])
        );
    end

    assign out_start = hold ? '0 : lane_start;
    assign busy      = (state_q != IDLE);
    assign done      = done_c & ~RST;
    assign vec_count = vec_count_q;

    // Tile sequencing: accept vectors, then count out the drain window.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_count_d = vec_count_q;
        done_c      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    vec_count_d = 16'd1;
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (acc) begin
                    vec_count_d = (vec_count_q == 16'hFFFF) ? vec_count_q : vec_count_q + 16'd1;
                    if (in_last) begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (!hold) begin
                    if (cnt_q == '0) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset overrides hold.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_count_q <= vec_count_d;
        end
    end

`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    // Held-while-busy cycle count, restarted on the first accept of each tile.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && acc) begin
            stall_d = '0;
        end else if (busy && hold) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (RST) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule : systolic_skew_feeder

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (N=4, DATA_W=16, MAC_LATENCY=3).
module tb_systolic_skew_feeder;
    import systolic_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned ML = 3;
    localparam int unsigned VW = N * DW;

    logic          clk = 1'b0;
    logic          RST, in_valid, in_last, hold;
    logic          in_ready, busy, done;
    logic [VW-1:0] in_vec, out_vec;
    logic [N-1:0]  out_start;
    logic [15:0]   vec_count;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .N           (N),
        .DATA_W      (DW),
        .MAC_LATENCY (ML)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .hold      (hold),
        .out_vec   (out_vec),
        .out_start (out_start),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count)
`ifdef SKEW_FEEDER_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Reference model: history of chain inputs (index j = pushed j+1 unheld edges ago),
    // plus tile bookkeeping.
    logic [VW-1:0] hv [N];
    logic          hs [N];
    bit            m_busy, m_drain;
    int            m_left;
    int unsigned   m_count;
`ifdef SKEW_FEEDER_STALL_CNT_EN
    logic [31:0]   m_stall;
`endif
    logic          s_done, s_start0;

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            hv[k] = '0;
            hs[k] = 1'b0;
        end
        m_busy = 0; m_drain = 0; m_left = 0; m_count = 0;
`ifdef SKEW_FEEDER_STALL_CNT_EN
        m_stall = '0;
`endif
    endtask

    task automatic drive(input logic r, input logic v, input logic l, input logic h, input logic [VW-1:0] d);
        RST = r; in_valid = v; in_last = l; hold = h; in_vec = d;
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock cycle: compare outputs against the model, then advance the model.
    task automatic tick(input string tag);
        logic [VW-1:0] ev;
        logic [N-1:0]  es;
        logic          er, ed, eb, acc;
        logic [15:0]   ec;
        @(negedge clk);
        er  = !RST && !hold && !m_drain;
        acc = in_valid && er;
        ed  = !RST && m_drain && !hold && (m_left == 1);
        eb  = m_busy;
        ec  = m_count[15:0];
        for (int k = 0; k < N; k++) begin
            ev[k*DW +: DW] = hv[k][k*DW +: DW];
            es[k]          = hold ? 1'b0 : hs[k];
        end
        tests++;
        if ({in_ready, done, busy, out_start, out_vec, vec_count} !== {er, ed, eb, es, ev, ec}) begin
            fails++;
            $display("FAIL %s t=%0t: got rdy=%b done=%b busy=%b start=%b vec=%h cnt=%0d, expected rdy=%b done=%b busy=%b start=%b vec=%h cnt=%0d",
                     tag, $time, in_ready, done, busy, out_start, out_vec, vec_count, er, ed, eb, es, ev, ec);
        end
`ifdef SKEW_FEEDER_STALL_CNT_EN
        tests++;
        if (stall_cycles !== m_stall) begin
            fails++;
            $display("FAIL %s stall t=%0t: got %0d, expected %0d", tag, $time, stall_cycles, m_stall);
        end
`endif
        s_done   = done;
        s_start0 = out_start[0];
        @(posedge clk);
        if (RST) begin
            model_clear();
        end else begin
`ifdef SKEW_FEEDER_STALL_CNT_EN
            if (!m_busy && acc) m_stall = '0;
            else if (m_busy && hold) m_stall = m_stall + 32'd1;
`endif
            if (!hold) begin
                for (int k = N - 1; k > 0; k--) begin
                    hv[k] = hv[k-1];
                    hs[k] = hs[k-1];
                end
                hv[0] = acc ? in_vec : '0;
                hs[0] = acc;
                if (m_drain) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_drain = 0;
                        m_busy  = 0;
                    end
                end else if (acc) begin
                    m_count = m_busy ? ((m_count == 65535) ? 65535 : m_count + 1) : 1;
                    m_busy  = 1;
                    if (in_last) begin
                        m_drain = 1;
                        m_left  = N + ML;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        model_clear();
    endtask

    typedef struct {
        logic          rst, valid, last, hold;
        logic [VW-1:0] vec;
        logic          ready, busy, done;
        logic [N-1:0]  start;
        logic [VW-1:0] ovec;
        logic [15:0]   cnt;
    } row_t;

    function automatic row_t mk(input logic r, input logic v, input logic l, input logic [VW-1:0] d,
                                input logic rdy, input logic b, input logic dn,
                                input logic [N-1:0] s, input logic [VW-1:0] o, input logic [15:0] c);
        row_t x;
        x.rst = r; x.valid = v; x.last = l; x.hold = 1'b0; x.vec = d;
        x.ready = rdy; x.busy = b; x.done = dn; x.start = s; x.ovec = o; x.cnt = c;
        return x;
    endfunction

    row_t tbl [10];

    initial begin
        logic [VW-1:0] v1;
        int done_idx, start_idx, done_cnt;

        v1 = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then a single-vector tile accepted at the end of row 1.
        tbl[0] = mk(1, 0, 0, '0, 0, 0, 0, 4'b0000, '0, 16'd0);
        tbl[1] = mk(0, 1, 1, v1, 1, 0, 0, 4'b0000, '0, 16'd0);
        tbl[2] = mk(0, 0, 0, '0, 0, 1, 0, 4'b0001, 64'h0000_0000_0000_3C00, 16'd1);
        tbl[3] = mk(0, 0, 0, '0, 0, 1, 0, 4'b0010, 64'h0000_0000_4000_0000, 16'd1);
        tbl[4] = mk(0, 0, 0, '0, 0, 1, 0, 4'b0100, 64'h0000_4200_0000_0000, 16'd1);
        tbl[5] = mk(0, 0, 0, '0, 0, 1, 0, 4'b1000, 64'h4400_0000_0000_0000, 16'd1);
        tbl[6] = mk(0, 0, 0, '0, 0, 1, 0, 4'b0000, '0, 16'd1);
        tbl[7] = mk(0, 0, 0, '0, 0, 1, 0, 4'b0000, '0, 16'd1);
        tbl[8] = mk(0, 0, 0, '0, 0, 1, 1, 4'b0000, '0, 16'd1);
        tbl[9] = mk(0, 0, 0, '0, 1, 0, 0, 4'b0000, '0, 16'd1);

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].last, tbl[i].hold, tbl[i].vec);
            @(negedge clk);
            tests++;
            if ({in_ready, busy, done, out_start, out_vec, vec_count} !==
                {tbl[i].ready, tbl[i].busy, tbl[i].done, tbl[i].start, tbl[i].ovec, tbl[i].cnt}) begin
                fails++;
                $display("FAIL table row %0d: got rdy=%b busy=%b done=%b start=%b vec=%h cnt=%0d, expected rdy=%b busy=%b done=%b start=%b vec=%h cnt=%0d",
                         i, in_ready, busy, done, out_start, out_vec, vec_count,
                         tbl[i].ready, tbl[i].busy, tbl[i].done, tbl[i].start, tbl[i].ovec, tbl[i].cnt);
            end
            @(posedge clk);
            #1;
        end

        // Burst of three back-to-back vectors.
        apply_reset();
        done_idx = -1;
        for (int idx = 0; idx < 25; idx++) begin
            if (idx < 3) drive(1'b0, 1'b1, idx == 2, 1'b0, {$urandom, $urandom});
            else         drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            tick("burst");
            if (s_done && done_idx < 0) done_idx = idx;
        end
        check_eq("burst done cycle", done_idx, 9);
        check_eq("burst vec_count", int'(vec_count), 3);

        // Two held cycles in STREAM push done two cycles later.
        apply_reset();
        done_idx = -1;
        for (int idx = 0; idx < 25; idx++) begin
            if (idx == 0)                drive(1'b0, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
            else if (idx == 1 || idx == 2) drive(1'b0, 1'b1, 1'b0, 1'b1, {$urandom, $urandom});
            else if (idx == 3)           drive(1'b0, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
            else if (idx == 4)           drive(1'b0, 1'b1, 1'b1, 1'b0, {$urandom, $urandom});
            else                         drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            tick("hold");
            if (s_done && done_idx < 0) done_idx = idx;
        end
        check_eq("hold done cycle", done_idx, 11);
        check_eq("hold vec_count", int'(vec_count), 3);
`ifdef SKEW_FEEDER_STALL_CNT_EN
        check_eq("hold stall_cycles", int'(stall_cycles), 2);
`endif

        // Reset while draining (drain counter at 3): no done afterwards.
        apply_reset();
        done_cnt = 0;
        for (int idx = 0; idx < 16; idx++) begin
            if (idx == 0)      drive(1'b0, 1'b1, 1'b1, 1'b0, v1);
            else if (idx == 4) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
            else               drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            tick("rst_drain");
            if (s_done) done_cnt++;
        end
        check_eq("rst_drain done pulses", done_cnt, 0);
        check_eq("rst_drain out_vec zero", int'(out_vec != '0), 0);

        // in_valid held high through DRAIN is accepted only after done.
        apply_reset();
        start_idx = -1;
        for (int idx = 0; idx < 25; idx++) begin
            if (idx == 0)      drive(1'b0, 1'b1, 1'b1, 1'b0, v1);
            else if (idx <= 8) drive(1'b0, 1'b1, 1'b1, 1'b0, {4{16'h1234}});
            else               drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
            tick("drain_valid");
            if (idx >= 2 && s_start0 && start_idx < 0) start_idx = idx;
        end
        check_eq("drain_valid first new start", start_idx, 9);

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 200) == 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
                  ($urandom % 5) == 0, {$urandom, $urandom});
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_systolic_skew_feeder
